// File: rtl/rfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rfile_pkg
// Brief    : Shared defaults and typedefs for the multi-port register file.
// Revision : 1.0  initial release
// ============================================================================
package rfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREGS  = 2 ** RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] reg_addr_t;
    typedef logic [RF_DATA_W-1:0] reg_data_t;

endpackage : rfile_pkg
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Brief    : Read/write/mark bus between the pipeline (master) and the
//            register file (slave). Read ports are packed, port i at
//            [i*W +: W].
// Revision : 1.0  initial release
// ============================================================================
interface regfile_mp_if
    import rfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NRD    = 2
)();

    logic [NRD*ADDR_W-1:0] ra;
    logic [NRD*DATA_W-1:0] rd;
    logic [NRD-1:0]        rbusy;
    logic                  we0;
    logic [ADDR_W-1:0]     wa0;
    logic [DATA_W-1:0]     wd0;
    logic                  we1;
    logic [ADDR_W-1:0]     wa1;
    logic [DATA_W-1:0]     wd1;
    logic                  mark_v;
    logic [ADDR_W-1:0]     mark_a;

    modport master (
        output ra, we0, wa0, wd0, we1, wa1, wd1, mark_v, mark_a,
        input  rd, rbusy
    );

    modport slave (
        input  ra, we0, wa0, wd0, we1, wa1, wd1, mark_v, mark_a,
        output rd, rbusy
    );

endinterface : regfile_mp_if
`default_nettype wire

// File: rtl/rfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rfile_scoreboard
// Brief    : Busy bit per register. A mark sets, a write-back clears, and a
//            mark wins over a same-cycle clear since it names a younger
//            producer. r0 is never busy.
//            Build option RFILE_BYPASS_EN: a same-cycle clear is reflected on
//            the lookup ports immediately (unless re-marked that cycle).
// Revision : 1.0  initial release
// ============================================================================
module rfile_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  we0_i,
    input  wire logic [ADDR_W-1:0]     wa0_i,
    input  wire logic                  we1_i,
    input  wire logic [ADDR_W-1:0]     wa1_i,
    input  wire logic                  mark_v_i,
    input  wire logic [ADDR_W-1:0]     mark_a_i,
    input  wire logic [NRD*ADDR_W-1:0] ra_i,
    output logic      [NRD-1:0]        rbusy_o
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;

    // Decode per-register clear/set requests and form the next busy vector.
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int r = 1; r < NREGS; r++) begin
            w_clr[r] = (we0_i && (wa0_i == ADDR_W'(r))) ||
                       (we1_i && (wa1_i == ADDR_W'(r)));
            w_set[r] = mark_v_i && (mark_a_i == ADDR_W'(r));
        end
        busy_d = w_set | (busy_q & ~w_clr);
    end

    // Busy state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-port busy lookup; w_clr/w_set are zero for r0 so it reads not-busy.
    always_comb begin
        rbusy_o = '0;
        for (int i = 0; i < NRD; i++) begin
`ifdef RFILE_BYPASS_EN
            rbusy_o[i] = busy_q[ra_i[i*ADDR_W +: ADDR_W]] &
                         ~(w_clr[ra_i[i*ADDR_W +: ADDR_W]] &
                           ~w_set[ra_i[i*ADDR_W +: ADDR_W]]);
`else
            rbusy_o[i] = busy_q[ra_i[i*ADDR_W +: ADDR_W]];
`endif
        end
    end

endmodule : rfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : NRD-read / 2-write register file with hardwired-zero r0 and an
//            integrated busy scoreboard. Write port 0 has priority over port 1
//            on a same-address collision.
//            Build option RFILE_BYPASS_EN: same-cycle write data is forwarded
//            to matching read ports.
// Revision : 1.0  initial release
// ============================================================================
module regfile_mp
    import rfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NRD    = 2
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    regfile_mp_if.slave bus
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]     mem_q [NREGS];
    logic [NRD*DATA_W-1:0] w_rd;

    // Storage: r0 is only ever reset, so it stays zero; port 0 wins collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (bus.we0 && (bus.wa0 == ADDR_W'(r))) begin
                    mem_q[r] <= bus.wd0;
                end else if (bus.we1 && (bus.wa1 == ADDR_W'(r))) begin
                    mem_q[r] <= bus.wd1;
                end
            end
        end
    end

    // Combinational read muxes; forwarding is suppressed for r0 and in reset.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NRD; i++) begin
`ifdef RFILE_BYPASS_EN
            if (rst_n && bus.we0 && (bus.wa0 == bus.ra[i*ADDR_W +: ADDR_W]) &&
                (bus.wa0 != '0)) begin
                w_rd[i*DATA_W +: DATA_W] = bus.wd0;
            end else if (rst_n && bus.we1 &&
                         (bus.wa1 == bus.ra[i*ADDR_W +: ADDR_W]) &&
                         (bus.wa1 != '0)) begin
                w_rd[i*DATA_W +: DATA_W] = bus.wd1;
            end else begin
                w_rd[i*DATA_W +: DATA_W] = mem_q[bus.ra[i*ADDR_W +: ADDR_W]];
            end
`else
            w_rd[i*DATA_W +: DATA_W] = mem_q[bus.ra[i*ADDR_W +: ADDR_W]];
`endif
        end
    end

    assign bus.rd = w_rd;

    rfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NRD    (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .we0_i    (bus.we0),
        .wa0_i    (bus.wa0),
        .we1_i    (bus.we1),
        .wa1_i    (bus.wa1),
        .mark_v_i (bus.mark_v),
        .mark_a_i (bus.mark_a),
        .ra_i     (bus.ra),
        .rbusy_o  (bus.rbusy)
    );

endmodule : regfile_mp
`default_nettype wire
